// File: rtl/reg_file.sv
// Eight-entry register bank (T1..T4, R1..R4) with masked clear/load/dec/inc and two combinational read ports.
// Define REG_FILE_SAT_EN to make increment/decrement saturate instead of wrapping.
module reg_file #(
    parameter int NBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBits-1:0] i,
    input  logic [1:0]       funsel,
    input  logic [3:0]       rsel,
    input  logic [3:0]       tsel,
    input  logic [2:0]       outasel,
    input  logic [2:0]       outbsel,
    output logic [NBits-1:0] outa,
    output logic [NBits-1:0] outb
);

    // Slot order matches the read-select encoding: 0..3 = T1..T4, 4..7 = R1..R4.
    logic [7:0]       w_en;
    logic [NBits-1:0] w_vals [8];

    assign w_en = {rsel, tsel};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            logic [NBits-1:0] r_val;
            logic [NBits-1:0] w_next;

            always_comb begin
                w_next = r_val;
                case (funsel)
                    2'b00: w_next = '0;
                    2'b01: w_next = i;
`ifdef REG_FILE_SAT_EN
                    2'b10: w_next = (r_val == '0) ? r_val : r_val - NBits'(1);
                    2'b11: w_next = (r_val == '1) ? r_val : r_val + NBits'(1);
`else
                    2'b10: w_next = r_val - NBits'(1);
                    2'b11: w_next = r_val + NBits'(1);
`endif
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_val <= '0;
                end else if (w_en[gi]) begin
                    r_val <= w_next;
                end
            end

            assign w_vals[gi] = r_val;
        end
    endgenerate

    assign outa = w_vals[outasel];
    assign outb = w_vals[outbsel];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written reset sequences,
// and randomized operations checked against an integer-array reference model.
module tb_reg_file;

`ifdef REG_FILE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i = '0;
    logic [1:0] funsel = '0;
    logic [3:0] rsel = '0;
    logic [3:0] tsel = '0;
    logic [2:0] outasel = '0;
    logic [2:0] outbsel = '0;
    logic [7:0] outa;
    logic [7:0] outb;

    int tests = 0;
    int fails = 0;

    reg_file #(.NBits(8)) dut (
        .clk(clk), .rst(rst), .i(i), .funsel(funsel), .rsel(rsel), .tsel(tsel),
        .outasel(outasel), .outbsel(outbsel), .outa(outa), .outb(outb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] f;
        logic [7:0] d;
        logic [3:0] r;
        logic [3:0] t;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs [21];
    int   model [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] f, input logic [7:0] d, input logic [3:0] r,
                                input logic [3:0] t, input logic [2:0] sa, input logic [2:0] sb,
                                input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.f = f; v.d = d; v.r = r; v.t = t; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    // Drive one operation between edges, then sample after the rising edge.
    task automatic step(input logic [1:0] f, input logic [7:0] d, input logic [3:0] r,
                        input logic [3:0] t, input logic [2:0] sa, input logic [2:0] sb);
        @(negedge clk);
        funsel = f; i = d; rsel = r; tsel = t; outasel = sa; outbsel = sb;
        @(posedge clk);
        #1;
    endtask

    function automatic int apply_op(input int v, input logic [1:0] f, input logic [7:0] d);
        case (f)
            2'b00:   return 0;
            2'b01:   return int'(d);
            2'b10:   return SAT ? ((v == 0) ? 0 : v - 1) : (v + 255) % 256;
            default: return SAT ? ((v == 255) ? 255 : v + 1) : (v + 1) % 256;
        endcase
    endfunction

    initial begin
        // Sequential directed table starting from reset state.
        vecs[0]  = mk(2'b01, 8'hA5, 4'b0001, 4'b0000, 3'd4, 3'd0, 8'hA5, 8'h00);
        vecs[1]  = mk(2'b00, 8'h00, 4'b0000, 4'b0000, 3'd5, 3'd1, 8'h00, 8'h00);
        vecs[2]  = mk(2'b01, 8'h3C, 4'b1010, 4'b0100, 3'd5, 3'd2, 8'h3C, 8'h3C);
        vecs[3]  = mk(2'b00, 8'h00, 4'b0000, 4'b0000, 3'd7, 3'd2, 8'h3C, 8'h3C);
        vecs[4]  = mk(2'b00, 8'h00, 4'b0000, 4'b0000, 3'd4, 3'd0, 8'hA5, 8'h00);
        vecs[5]  = mk(2'b00, 8'h00, 4'b0000, 4'b0000, 3'd6, 3'd3, 8'h00, 8'h00);
        vecs[6]  = mk(2'b01, 8'hFE, 4'b0000, 4'b0001, 3'd0, 3'd0, 8'hFE, 8'hFE);
        vecs[7]  = mk(2'b11, 8'h00, 4'b0000, 4'b0001, 3'd0, 3'd4, 8'hFF, 8'hA5);
        vecs[8]  = mk(2'b11, 8'h00, 4'b0000, 4'b0001, 3'd0, 3'd1, SAT ? 8'hFF : 8'h00, 8'h00);
        vecs[9]  = mk(2'b11, 8'h00, 4'b0000, 4'b0001, 3'd0, 3'd7, SAT ? 8'hFF : 8'h01, 8'h3C);
        vecs[10] = mk(2'b00, 8'h00, 4'b0100, 4'b0000, 3'd6, 3'd0, 8'h00, SAT ? 8'hFF : 8'h01);
        vecs[11] = mk(2'b10, 8'h00, 4'b0100, 4'b0000, 3'd6, 3'd7, SAT ? 8'h00 : 8'hFF, 8'h3C);
        vecs[12] = mk(2'b10, 8'h00, 4'b0100, 4'b0000, 3'd6, 3'd6, SAT ? 8'h00 : 8'hFE, SAT ? 8'h00 : 8'hFE);
        vecs[13] = mk(2'b01, 8'h10, 4'b0001, 4'b0000, 3'd4, 3'd5, 8'h10, 8'h3C);
        vecs[14] = mk(2'b01, 8'h20, 4'b0010, 4'b0000, 3'd4, 3'd5, 8'h10, 8'h20);
        for (int k = 0; k < 5; k++) begin
            vecs[15 + k] = mk(2'b11, 8'h00, 4'b0011, 4'b0000, 3'd4, 3'd5,
                              8'h11 + 8'(k), 8'h21 + 8'(k));
        end
        vecs[20] = mk(2'b00, 8'h00, 4'b0000, 4'b0000, 3'd5, 3'd5, 8'h25, 8'h25);

        // Reset state: every register reads zero while rst is held.
        #2;
        for (int s = 0; s < 8; s++) begin
            outasel = 3'(s); outbsel = 3'(7 - s);
            #1;
            check($sformatf("reset_a%0d", s), outa, 8'h00);
            check($sformatf("reset_b%0d", 7 - s), outb, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 21; n++) begin
            step(vecs[n].f, vecs[n].d, vecs[n].r, vecs[n].t, vecs[n].sa, vecs[n].sb);
            $display("[TB] vec %0d f=%b i=%02h r=%b t=%b a(%0d)=%02h b(%0d)=%02h", n, vecs[n].f,
                     vecs[n].d, vecs[n].r, vecs[n].t, vecs[n].sa, outa, vecs[n].sb, outb);
            check($sformatf("vec%0d_a", n), outa, vecs[n].ea);
            check($sformatf("vec%0d_b", n), outb, vecs[n].eb);
        end

        // Async reset in the middle of an increment run on R1.
        step(2'b01, 8'h07, 4'b0001, 4'b0000, 3'd4, 3'd5);
        check("mid_load", outa, 8'h07);
        @(negedge clk);
        funsel = 2'b11; rsel = 4'b0001; tsel = 4'b0000;
        rst = 1'b1;
        #1;
        check("async_rst_a", outa, 8'h00);
        check("async_rst_b", outb, 8'h00);
        $display("[TB] async reset mid-run outa=%02h outb=%02h", outa, outb);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_after_rst", outa, 8'h01);
        $display("[TB] first edge after reset outa=%02h", outa);

        // Reset held across an edge dominates an active load.
        @(negedge clk);
        funsel = 2'b01; i = 8'h5A; rsel = 4'b1111; tsel = 4'b1111; outasel = 3'd4; outbsel = 3'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dominates_a", outa, 8'h00);
        check("rst_dominates_b", outb, 8'h00);
        $display("[TB] reset over load edge outa=%02h outb=%02h", outa, outb);
        @(negedge clk);
        rsel = 4'b0000; tsel = 4'b0000;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 0;

        // Randomized operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [1:0] f;
            logic [7:0] d;
            logic [3:0] r;
            logic [3:0] t;
            logic [2:0] sa;
            logic [2:0] sb;
            f  = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            r  = 4'($urandom_range(0, 15));
            t  = 4'($urandom_range(0, 15));
            sa = 3'($urandom_range(0, 7));
            sb = 3'($urandom_range(0, 7));
            if (n % 4 == 0) d = (n % 8 == 0) ? 8'hFF : 8'h00;
            for (int k = 0; k < 8; k++) begin
                if ((k < 4) ? t[k] : r[k - 4]) model[k] = apply_op(model[k], f, d);
            end
            step(f, d, r, t, sa, sb);
            $display("[TB] rnd %0d f=%b i=%02h r=%b t=%b a(%0d)=%02h b(%0d)=%02h",
                     n, f, d, r, t, sa, outa, sb, outb);
            check($sformatf("rnd%0d_a", n), outa, 8'(model[sa]));
            check($sformatf("rnd%0d_b", n), outb, 8'(model[sb]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Bank of general-purpose (R1..R4) and temporary (T1..T4) registers, each implementing the team's 2-bit function-select register operations: clear, load, decrement and increment.
- A shared input bus is written into any masked subset of registers.
- Two independent read ports (A, B) select any register.
- Outputs feed the ALU operand inputs; the input bus is driven by the ALU result / memory mux.

Parameters:
- NBits, 8, data width of every register and of the i/outa/outb buses.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- i  input  NBits  shared write-data bus.
- funsel  input  2  operation applied to every enabled register: 00 clear, 01 load, 10 decrement, 11 increment.
- rsel  input  4  per-register enable mask for R1..R4 (bit0=R1 .. bit3=R4), active-high.
- tsel  input  4  per-register enable mask for T1..T4 (bit0=T1 .. bit3=T4), active-high.
- outasel  input  3  read select A: 0..3 = T1..T4, 4..7 = R1..R4.
- outbsel  input  3  read select B, same encoding as outasel.
- outa  output  NBits  contents of the register selected by outasel.
- outb  output  NBits  contents of the register selected by outbsel.

Behaviour:
- Reset: rst high forces all 8 registers to 0 immediately, independent of clk. outa = outb = 0 while rst is high. rst dominates any funsel/enable activity on the same edge.
- Per register, on a rising clk with its enable bit = 1:
  - 00: reg <= 0
  - 01: reg <= i
  - 10: reg <= reg - 1
  - 11: reg <= reg + 1
- Enable bit = 0: register holds its value.
- Arithmetic is modulo 2^NBits:
  - decrementing 0 yields all-ones;
  - incrementing all-ones yields 0.
- Multiple enable bits may be set together. Each enabled register applies funsel to its own current value; increment/decrement are independent per register.
- rsel = tsel = 0: no state change regardless of funsel.
- Reads are combinational from register state:
  - a write becomes visible on outa/outb after the clock edge, i.e. 1-cycle write-to-read latency;
  - no bypass from i.
- outasel and outbsel may select the same register; both outputs then show the same value.
- Reads never alter state.
- Reset asserted mid-sequence (e.g. during an increment run): registers drop to 0 asynchronously. Operation resumes on the first rising edge after rst deasserts, starting from 0.

Optional Feature:
- Macro: REG_FILE_SAT_EN.
- When defined:
  - increment saturates at all-ones (all-ones + 1 stays all-ones);
  - decrement saturates at 0 (0 - 1 stays 0);
  - clear and load are unaffected.
- When undefined: modulo wrap-around exactly as in Behaviour.
- The port list is identical in both builds.

Test Plan (all cases NBits=8):
- Reset/load/read:
  - assert rst, then release;
  - funsel=01, i=8'hA5, rsel=4'b0001;
  - then outasel=4, outbsel=0;
  - expect outa=8'hA5 after the edge, outb=8'h00, all other registers 0.
- Multi-write and hold:
  - funsel=01, i=8'h3C, rsel=4'b1010, tsel=4'b0100 for one edge;
  - then rsel=tsel=0, funsel=00 for 3 edges;
  - expect R2=R4=T3=8'h3C, all others 0, values held.
- Increment wrap:
  - load T1=8'hFE, then funsel=11, tsel=4'b0001 for 3 edges;
  - expect T1 sequence FF, 00, 01;
  - with REG_FILE_SAT_EN: expect FF, FF, FF.
- Decrement wrap:
  - R3 cleared, then funsel=10, rsel=4'b0100 for 2 edges;
  - expect FF, FE;
  - with REG_FILE_SAT_EN: expect 00, 00.
- Simultaneous independent counters:
  - R1=8'h10, R2=8'h20;
  - funsel=11, rsel=4'b0011 for 5 edges;
  - expect R1=8'h15, R2=8'h25;
  - outasel=outbsel=5, expect outa=outb=8'h25.
- Async reset mid-operation:
  - during increment run with R1=8'h07, pulse rst between edges;
  - expect outa (sel R1) = 0 immediately, before any edge;
  - next edge after release yields 8'h01.
